// File: rtl/preprint_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module  : preprint_sequencer_if
// Brief   : Front-panel / motor / heater signal bundle for preprint_sequencer.
// Revision: 1.0 - initial release
// =============================================================================
interface preprint_sequencer_if #(
   parameter int N_AXES = 3
);
   logic              start;
   logic              abort;
   logic [1:0]        material;
   logic [N_AXES-1:0] endstop;
   logic [N_AXES-1:0] motor_en;
   logic              motor_dir;
   logic              bed_heat;
   logic              hot_heat;
   logic [2:0]        state_code;
   logic              ready;
   logic              error;

   modport master (
      output start, abort, material, endstop,
      input  motor_en, motor_dir, bed_heat, hot_heat, state_code, ready, error
   );

   modport slave (
      input  start, abort, material, endstop,
      output motor_en, motor_dir, bed_heat, hot_heat, state_code, ready, error
   );
endinterface
`default_nettype wire

// File: rtl/preprint_sequencer.sv
`default_nettype none
// =============================================================================
// Module  : preprint_sequencer
// Brief   : Debounced start, sequential axis homing, bed then hotend heating
//           phases timed per material, READY hold. Define HOMING_TIMEOUT_EN to
//           add a per-axis homing timeout that drops into ERROR.
// Revision: 1.0 - initial release
// =============================================================================
module preprint_sequencer #(
   parameter int N_AXES     = 3,
   parameter int TIMER_W    = 16,
   parameter int DEB_CYCLES = 4,
   parameter int BED_TICKS  = 12,
   parameter int PLA_TICKS  = 8,
   parameter int ABS_TICKS  = 10,
   parameter int TPU_TICKS  = 8,
   parameter int HOME_TMO   = 1000
) (
   input  logic                clk,
   input  logic                reset,
   preprint_sequencer_if.slave bus
);
   localparam int c_axis_w = (N_AXES > 1) ? $clog2(N_AXES) : 1;

   localparam logic [TIMER_W-1:0]  c_deb_max   = TIMER_W'(DEB_CYCLES);
   localparam logic [TIMER_W-1:0]  c_deb_last  = TIMER_W'(DEB_CYCLES - 1);
   localparam logic [TIMER_W-1:0]  c_bed_last  = TIMER_W'(BED_TICKS - 1);
   localparam logic [TIMER_W-1:0]  c_pla_last  = TIMER_W'(PLA_TICKS - 1);
   localparam logic [TIMER_W-1:0]  c_abs_last  = TIMER_W'(ABS_TICKS - 1);
   localparam logic [TIMER_W-1:0]  c_tpu_last  = TIMER_W'(TPU_TICKS - 1);
`ifdef HOMING_TIMEOUT_EN
   localparam logic [TIMER_W-1:0]  c_tmo_last  = TIMER_W'(HOME_TMO - 1);
`endif
   localparam logic [c_axis_w-1:0] c_last_axis = c_axis_w'(N_AXES - 1);
   localparam logic [N_AXES-1:0]   c_axis0_en  = N_AXES'(1);
   localparam logic [1:0]          c_mat_none  = 2'b00;
   localparam logic [1:0]          c_mat_abs   = 2'b10;
   localparam logic [1:0]          c_mat_tpu   = 2'b11;

   // Every phase length must fit the counter so no phase can wrap.
   generate
      if (DEB_CYCLES < 1 || BED_TICKS < 1 || PLA_TICKS < 1 || ABS_TICKS < 1 ||
          TPU_TICKS < 1 || HOME_TMO < 1 || N_AXES < 1 ||
          longint'(DEB_CYCLES) >= (longint'(1) << TIMER_W) ||
          longint'(BED_TICKS)  >= (longint'(1) << TIMER_W) ||
          longint'(PLA_TICKS)  >= (longint'(1) << TIMER_W) ||
          longint'(ABS_TICKS)  >= (longint'(1) << TIMER_W) ||
          longint'(TPU_TICKS)  >= (longint'(1) << TIMER_W) ||
          longint'(HOME_TMO)   >= (longint'(1) << TIMER_W)) begin : g_param_check
         $error("preprint_sequencer: cycle-count parameter out of range for TIMER_W");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HOME  = 3'd1,
      ST_BED   = 3'd2,
      ST_HOT   = 3'd3,
      ST_READY = 3'd4,
      ST_ERROR = 3'd7
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_axis_w-1:0] r_axis,  w_axis_nxt;
   logic [TIMER_W-1:0]  r_cnt,   w_cnt_nxt;
   logic [1:0]          r_mat,   w_mat_nxt;
   logic [TIMER_W-1:0]  r_deb;
   logic [TIMER_W-1:0]  w_hot_last;
   logic                w_accept;

   // Saturating run-length of start; the accept pulse fires only on the
   // transition into saturation, so a held button yields one pulse.
   always_ff @(posedge clk) begin
      if (reset || !bus.start) begin
         r_deb <= '0;
      end else if (r_deb != c_deb_max) begin
         r_deb <= r_deb + TIMER_W'(1);
      end
   end

   assign w_accept = bus.start && (r_deb == c_deb_last);

   always_comb begin
      case (r_mat)
         c_mat_abs: w_hot_last = c_abs_last;
         c_mat_tpu: w_hot_last = c_tpu_last;
         default:   w_hot_last = c_pla_last;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_axis  <= '0;
         r_cnt   <= '0;
         r_mat   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_axis  <= w_axis_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mat   <= w_mat_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_axis_nxt     = r_axis;
      w_cnt_nxt      = r_cnt;
      w_mat_nxt      = r_mat;
      bus.motor_en   = '0;
      bus.motor_dir  = 1'b0;
      bus.bed_heat   = 1'b0;
      bus.hot_heat   = 1'b0;
      bus.ready      = 1'b0;
      bus.error      = 1'b0;
      bus.state_code = r_state;

      if (bus.abort) begin
         w_state_nxt = ST_IDLE;
         w_axis_nxt  = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (bus.material == c_mat_none) begin
                     w_state_nxt = ST_ERROR;
                  end else begin
                     w_state_nxt = ST_HOME;
                     w_mat_nxt   = bus.material;
                     w_axis_nxt  = '0;
                     w_cnt_nxt   = '0;
                  end
               end
            end
            ST_HOME: begin
               if (bus.endstop[r_axis]) begin
                  w_cnt_nxt = '0;
                  if (r_axis == c_last_axis) begin
                     w_state_nxt = ST_BED;
                     w_axis_nxt  = '0;
                  end else begin
                     w_axis_nxt = r_axis + c_axis_w'(1);
                  end
               end
`ifdef HOMING_TIMEOUT_EN
               else if (r_cnt == c_tmo_last) begin
                  w_state_nxt = ST_ERROR;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + TIMER_W'(1);
               end
`endif
            end
            ST_BED: begin
               if (r_cnt == c_bed_last) begin
                  w_state_nxt = ST_HOT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + TIMER_W'(1);
               end
            end
            ST_HOT: begin
               if (r_cnt == w_hot_last) begin
                  w_state_nxt = ST_READY;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + TIMER_W'(1);
               end
            end
            ST_READY, ST_ERROR: begin
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end

      // Drives decode from registered state only, so they drop one edge after abort/reset.
      case (r_state)
         ST_HOME: begin
            bus.motor_en  = c_axis0_en << r_axis;
            bus.motor_dir = 1'b1;
         end
         ST_BED: begin
            bus.bed_heat = 1'b1;
         end
         ST_HOT: begin
            bus.bed_heat = 1'b1;
            bus.hot_heat = 1'b1;
         end
         ST_READY: begin
            bus.bed_heat = 1'b1;
            bus.hot_heat = 1'b1;
            bus.ready    = 1'b1;
         end
         ST_ERROR: begin
            bus.error = 1'b1;
         end
         default: begin
         end
      endcase
   end
endmodule
`default_nettype wire
